// File: rtl/serial_sum_deserializer_pkg.sv
// serial_sum_deserializer_pkg: shared types and sizing helpers for the
// serial sum deserializer and its optional reference adder.
package serial_sum_deserializer_pkg;

    // Frame assembly state: waiting for a start bit, or collecting bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_REGLENGTH = 3;

    // A frame is the operand-width sum bits plus the final carry bit.
    function automatic int frame_len(input int reglength);
        return reglength + 1;
    endfunction

    // Bit counter must hold every value from 0 up to the frame length.
    function automatic int cnt_width(input int reglength);
        return $clog2(reglength + 2);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_REGLENGTH);

endpackage

// File: rtl/serial_sum_deserializer_ref_adder.sv
// serial_ref_adder: 1-bit full adder with a carry flop, used to recompute
// the expected serial sum bit while a frame is being received. Asserting
// clr_i forces a zero carry-in for the current bit (the first bit of a frame).
module serial_ref_adder
    import serial_sum_deserializer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    logic carry_q;
    logic carry_d;
    logic carry_in;

    // Full-adder sum and next carry; carry only advances on accepted bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        carry_d  = carry_q;
        carry_in = clr_i ? 1'b0 : carry_q;
        sum_o    = a_i ^ b_i ^ carry_in;
        if (en_i) begin
            carry_d = (a_i & b_i) | (a_i & carry_in) | (b_i & carry_in);
        end
    end

    // Carry register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= so all flops update from pre-edge values.
            carry_q <= carry_d;
        end
    end

    assign carry_o = carry_q;

endmodule

// File: rtl/serial_sum_deserializer.sv
// serial_sum_deserializer: collects an LSB-first serial sum stream
// (REGLENGTH sum bits, then the carry) into a REGLENGTH+1-bit word and holds
// it under a valid/ack handshake, flagging overruns and restarted frames.
// Optional build macro SERIAL_SUM_CHECK_EN adds a_bit/b_bit inputs and a
// sum_err output driven by an internal reference serial adder.
module serial_sum_deserializer
    import serial_sum_deserializer_pkg::*;
#(
    parameter int REGLENGTH = DEFAULT_REGLENGTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 res_ack,
    output logic [REGLENGTH:0]   result,
    output logic                 result_valid,
    output logic                 overrun,
    output logic                 frame_restart
`ifdef SERIAL_SUM_CHECK_EN
   ,input  logic                 a_bit,
    input  logic                 b_bit,
    output logic                 sum_err
`endif
);

    localparam int FRAME_LEN = frame_len(REGLENGTH);
    localparam int CNT_W     = cnt_width(REGLENGTH);
    // Count value held while the final (carry) bit is expected.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REGLENGTH);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    // Partial bits only; the final bit goes straight into the result.
    logic [REGLENGTH-1:0]   sr_q, sr_d;
    logic [FRAME_LEN-1:0]   result_q, result_d;
    logic                   result_valid_q, result_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_restart_q, frame_restart_d;

    logic                   frame_start;
    logic                   complete;

    // Next-state logic: frame start/restart, shifting, completion, handshake.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        sr_d            = sr_q;
        result_d        = result_q;
        result_valid_d  = result_valid_q;
        overrun_d       = overrun_q;
        frame_restart_d = 1'b0;
        frame_start     = 1'b0;
        complete        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bit_valid && start) begin
                    frame_start = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    if (start) begin
                        // A start mid-frame wins even on the final bit.
                        frame_start     = 1'b1;
                        frame_restart_d = 1'b1;
                    end else if (cnt_q == LAST_CNT) begin
                        complete = 1'b1;
                    end else begin
                        sr_d  = {bit_in, sr_q[REGLENGTH-1:1]};
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // First bit enters at the top and walks down to bit 0 as the frame fills.
        if (frame_start) begin
            sr_d    = {bit_in, {(REGLENGTH-1){1'b0}}};
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
        end

        if (complete) begin
            result_d       = {bit_in, sr_q};
            result_valid_d = 1'b1;
            cnt_d          = '0;
            state_d        = IDLE;
            if (result_valid_q && !res_ack) begin
                overrun_d = 1'b1;
            end
        end else if (result_valid_q && res_ack) begin
            result_valid_d = 1'b0;
        end
    end

    // Frame, result and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            // NOTE: the shift register is reset too, so an aborted frame leaves no stale bits.
            sr_q            <= '0;
            result_q        <= '0;
            result_valid_q  <= 1'b0;
            overrun_q       <= 1'b0;
            frame_restart_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            sr_q            <= sr_d;
            result_q        <= result_d;
            result_valid_q  <= result_valid_d;
            overrun_q       <= overrun_d;
            frame_restart_q <= frame_restart_d;
        end
    end

    assign result        = result_q;
    assign result_valid  = result_valid_q;
    assign overrun       = overrun_q;
    assign frame_restart = frame_restart_q;

`ifdef SERIAL_SUM_CHECK_EN
    logic accept;
    logic ref_sum;
    logic ref_carry;
    logic exp_bit;
    logic bit_mismatch;
    logic err_acc_q, err_acc_d;
    logic sum_err_q, sum_err_d;

    serial_ref_adder u_ref_adder (
        .clk     (clk),
        .reset   (reset),
        .en_i    (accept),
        .clr_i   (frame_start),
        .a_i     (a_bit),
        .b_i     (b_bit),
        .sum_o   (ref_sum),
        .carry_o (ref_carry)
    );

    // Compare each accepted bit with the reference; the final bit is the carry.
    always_comb begin
        accept       = frame_start || ((state_q == SHIFT) && bit_valid);
        exp_bit      = complete ? ref_carry : ref_sum;
        bit_mismatch = accept && (bit_in != exp_bit);
        err_acc_d    = err_acc_q;
        sum_err_d    = sum_err_q;

        if (frame_start) begin
            err_acc_d = bit_mismatch;
        end else if (accept && !complete) begin
            err_acc_d = err_acc_q | bit_mismatch;
        end

        if (complete) begin
            sum_err_d = err_acc_q | bit_mismatch;
            err_acc_d = 1'b0;
        end else if (result_valid_q && res_ack) begin
            sum_err_d = 1'b0;
        end
    end

    // Per-frame error accumulator and the error flag presented with the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_acc_q <= 1'b0;
            sum_err_q <= 1'b0;
        end else begin
            err_acc_q <= err_acc_d;
            sum_err_q <= sum_err_d;
        end
    end

    assign sum_err = sum_err_q;
`endif

endmodule

// File: tb/tb_serial_sum_deserializer.sv
// tb_serial_sum_deserializer: directed stimulus with a queue-based frame
// model compared against the DUT on every falling edge, plus literal checks.
module tb_serial_sum_deserializer;
    import serial_sum_deserializer_pkg::*;

    localparam int REGLENGTH = 3;
    localparam int FRAME_LEN = frame_len(REGLENGTH);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic bit_in = 1'b0;
    logic bit_valid = 1'b0;
    logic res_ack = 1'b0;
    logic a_bit = 1'b0;
    logic b_bit = 1'b0;
    logic [REGLENGTH:0] result;
    logic result_valid;
    logic overrun;
    logic frame_restart;
    logic sum_err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    serial_sum_deserializer #(.REGLENGTH(REGLENGTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .res_ack       (res_ack),
        .result        (result),
        .result_valid  (result_valid),
        .overrun       (overrun),
        .frame_restart (frame_restart)
`ifdef SERIAL_SUM_CHECK_EN
       ,.a_bit         (a_bit),
        .b_bit         (b_bit),
        .sum_err       (sum_err)
`endif
    );

`ifndef SERIAL_SUM_CHECK_EN
    assign sum_err = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [REGLENGTH:0] m_result = '0;
    bit m_valid = 1'b0;
    bit m_overrun = 1'b0;
    bit m_restart = 1'b0;
    bit m_sum_err = 1'b0;
    bit m_in_frame = 1'b0;
    bit m_bits[$];
    bit m_a[$];
    bit m_b[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_result = '0; m_valid = 0; m_overrun = 0; m_restart = 0;
            m_sum_err = 0; m_in_frame = 0;
            m_bits.delete(); m_a.delete(); m_b.delete();
        end else begin : model_step
            bit done;
            int word, av, bv;
            done = 0;
            m_restart = 0;
            if (bit_valid && start) begin
                if (m_in_frame) m_restart = 1;
                m_in_frame = 1;
                m_bits = {bit_in}; m_a = {a_bit}; m_b = {b_bit};
            end else if (bit_valid && m_in_frame) begin
                m_bits.push_back(bit_in); m_a.push_back(a_bit); m_b.push_back(b_bit);
            end
            if (m_in_frame && m_bits.size() == FRAME_LEN) begin
                word = 0; av = 0; bv = 0;
                for (int i = 0; i < FRAME_LEN; i++) word += int'(m_bits[i]) << i;
                for (int i = 0; i < REGLENGTH; i++) begin
                    av += int'(m_a[i]) << i;
                    bv += int'(m_b[i]) << i;
                end
                if (m_valid && !res_ack) m_overrun = 1;
                m_valid = 1;
                m_result = word[REGLENGTH:0];
                m_sum_err = (word != av + bv);
                m_in_frame = 0;
                done = 1;
            end
            if (!done && m_valid && res_ack) begin
                m_valid = 0;
                m_sum_err = 0;
            end
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        check("m_result", 32'(result), 32'(m_result));
        check("m_valid", 32'(result_valid), 32'(m_valid));
        check("m_overrun", 32'(overrun), 32'(m_overrun));
        check("m_restart", 32'(frame_restart), 32'(m_restart));
`ifdef SERIAL_SUM_CHECK_EN
        check("m_sum_err", 32'(sum_err), 32'(m_sum_err));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic v, input logic s, input logic b, input logic ack,
                       input logic ab = 1'b0, input logic bb = 1'b0);
        @(negedge clk);
        bit_valid = v; start = s; bit_in = b; res_ack = ack; a_bit = ab; b_bit = bb;
    endtask

    task automatic idle(input logic ack = 1'b0);
        cyc(1'b0, 1'b0, 1'b0, ack);
    endtask

    // Sends a 4-bit frame LSB first, optionally acking on the last bit.
    task automatic send4(input logic [3:0] w, input logic ack_last);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, i == 0, w[i], (i == 3) ? ack_last : 1'b0);
        end
    endtask

    task automatic send_ab(input logic [3:0] s, input logic [2:0] a, input logic [2:0] b);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, i == 0, s[i], 1'b0, (i < 3) ? a[i] : 1'b1, (i < 3) ? b[i] : 1'b1);
        end
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_result", 32'(result), 32'h0);
        check("rst_valid", 32'(result_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_restart", 32'(frame_restart), 32'h0);
        reset = 1'b1;

        // Basic frame 5+6 = 1011, result one cycle after the last bit.
        send4(4'b1011, 1'b0);
        check("lat_pre_valid", 32'(result_valid), 32'h0);
        idle();
        check("basic_result", 32'(result), 32'hB);
        check("basic_valid", 32'(result_valid), 32'h1);
        idle(1'b1);
        idle();
        check("basic_ack_clears", 32'(result_valid), 32'h0);

        // Ignored inputs in IDLE, then a gapped frame.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0); idle(); idle();
        cyc(1'b1, 1'b0, 1'b1, 1'b0); idle(); idle();
        cyc(1'b1, 1'b0, 1'b0, 1'b0); idle(); idle();
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        check("gap_result", 32'(result), 32'hB);
        check("gap_valid", 32'(result_valid), 32'h1);
        idle(1'b1);
        idle();

        // Restart after two bits; new frame 0,1,1,0.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("restart_pulse", 32'(frame_restart), 32'h1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("restart_one_cycle", 32'(frame_restart), 32'h0);
        check("restart_no_old", 32'(result_valid), 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check("restart_result", 32'(result), 32'h6);
        check("restart_valid", 32'(result_valid), 32'h1);
        idle(1'b1);
        idle();

        // Start on the would-be final bit: no result, new frame 1,0,0,0.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        idle();
        check("final_restart_novalid", 32'(result_valid), 32'h0);
        check("final_restart_pulse", 32'(frame_restart), 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        check("final_restart_result", 32'(result), 32'h1);
        idle(1'b1);
        idle();

        // Overrun: back-to-back frames with no ack.
        send4(4'b1011, 1'b0);
        send4(4'b0111, 1'b0);
        idle();
        check("ovr_result", 32'(result), 32'h7);
        check("ovr_valid", 32'(result_valid), 32'h1);
        check("ovr_flag", 32'(overrun), 32'h1);
        idle(1'b1);
        repeat (3) idle();
        check("ovr_sticky", 32'(overrun), 32'h1);
        check("ovr_ack_valid", 32'(result_valid), 32'h0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check("ovr_reset_clears", 32'(overrun), 32'h0);
        reset = 1'b1;

        // Ack on the completion cycle of the second frame: no overrun.
        send4(4'b1011, 1'b0);
        send4(4'b0111, 1'b1);
        idle();
        check("ack_cmp_result", 32'(result), 32'h7);
        check("ack_cmp_valid", 32'(result_valid), 32'h1);
        check("ack_cmp_no_ovr", 32'(overrun), 32'h0);

        // Async reset mid-frame with a result still pending.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("pre_async_valid", 32'(result_valid), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("async_result", 32'(result), 32'h0);
        check("async_valid", 32'(result_valid), 32'h0);
        check("async_overrun", 32'(overrun), 32'h0);
        @(negedge clk); reset = 1'b1;
        send4(4'b1010, 1'b0);
        idle();
        check("post_reset_result", 32'(result), 32'hA);
        check("post_reset_valid", 32'(result_valid), 32'h1);
        idle(1'b1);
        idle();

`ifdef SERIAL_SUM_CHECK_EN
        // Correct stream for 5+6.
        send_ab(4'b1011, 3'b101, 3'b110);
        idle();
        check("chk_ok_valid", 32'(result_valid), 32'h1);
        check("chk_ok_err", 32'(sum_err), 32'h0);
        idle(1'b1);
        idle();
        // Bit 2 flipped.
        send_ab(4'b1111, 3'b101, 3'b110);
        idle();
        check("chk_bad_result", 32'(result), 32'hF);
        check("chk_bad_err", 32'(sum_err), 32'h1);
        idle(1'b1);
        idle();
        check("chk_err_cleared", 32'(sum_err), 32'h0);
`endif

        repeat (2) idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_sum_deserializer.md
Name: serial_sum_deserializer

Overview:
- Receiving end of the team's bit-serial adder datapath.
- Collects the LSB-first serial sum stream (REGLENGTH sum bits followed by the final carry bit) and reassembles it into a parallel REGLENGTH+1-bit result.
- Presents the result with a valid/ack hold handshake and flags overruns and aborted frames.
- Sits directly downstream of the serial full-adder output.

Parameters:
REGLENGTH, 3, operand width of the serial adder; a frame is REGLENGTH+1 bits.

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
start  input  1  marks first bit of a frame; qualified by bit_valid
bit_in  input  1  serial sum bit, LSB first
bit_valid  input  1  bit_in valid this cycle
res_ack  input  1  consumer accepts result this cycle
result  output  REGLENGTH+1  assembled sum; MSB is the carry
result_valid  output  1  result held and valid until acknowledged
overrun  output  1  sticky; a new result overwrote an unacknowledged one
frame_restart  output  1  one-cycle pulse; start arrived mid-frame

Behaviour:
- Reset values: result=0, result_valid=0, overrun=0, frame_restart=0, state=IDLE, bit count=0, shift register=0.
- States: IDLE, SHIFT.
- Bit counter width is $clog2(REGLENGTH+2).
- IDLE:
  - start&&bit_valid: load bit_in as bit 0, count=1, go to SHIFT.
  - start without bit_valid is ignored.
  - bit_valid without start is ignored.
- SHIFT:
  - Each bit_valid cycle shifts bit_in in at the MSB end: sr <= {bit_in, sr[REGLENGTH:1]}. Count increments.
  - Cycles without bit_valid hold state; there is no timeout.
- Completion: on the edge that samples bit number REGLENGTH+1:
  - result <= final assembled word.
  - result_valid <= 1.
  - State returns to IDLE.
  - Latency: result is visible in the cycle after the last bit.
- Back-to-back frames: the cycle after completion, the block accepts a new start with no bubble.
- Restart: start&&bit_valid while in SHIFT aborts the partial frame, loads bit_in as bit 0, sets count=1, and pulses frame_restart for one cycle.
  - If a start arrives on what would be the final bit, restart wins and no result is produced.
- Handshake:
  - result_valid stays high until res_ack is sampled high while result_valid==1; it then clears on that edge.
  - res_ack while result_valid==0 has no effect.
- Simultaneous completion and res_ack in the same cycle: the new result loads, result_valid stays 1, and overrun is not set.
- Completion while result_valid==1 and res_ack==0: result is overwritten, result_valid stays 1, overrun<=1.
  - overrun is sticky and cleared only by reset.
- Reset asserted mid-frame: the partial frame is discarded and all outputs return to their reset values asynchronously.

Optional Feature:
Macro SERIAL_SUM_CHECK_EN.
- Defined:
  - Adds input ports a_bit and b_bit, the serial operand bits sampled alongside each bit_in.
  - Also adds output sum_err (1 bit).
  - An internal reference full adder with a carry register recomputes the expected sum bit per cycle. Its carry clears at frame start and on restart.
  - On the final bit, the expected bit is the stored carry, and a_bit/b_bit are ignored.
  - Any mismatch within a frame causes sum_err to be asserted together with result_valid for that frame. sum_err clears when that result is acknowledged.
- Undefined: none of these ports or logic exist, and behaviour is otherwise identical.

Decomposition:
- Shared package:
  - State enum {IDLE, SHIFT}.
  - Function computing the frame length REGLENGTH+1.
  - Counter-width constant derived with $clog2.
- One natural sub-module, serial_ref_adder (1-bit full adder plus carry flop with clear). It is instantiated only under SERIAL_SUM_CHECK_EN.

Test Plan:
- REGLENGTH=3, sum 5+6: bits 1,1,0,1 LSB first with start on the first bit -> result=4'b1011 and result_valid=1 one cycle after the 4th bit; res_ack -> result_valid=0 on the next edge.
- Gapped bits: same frame with bit_valid low for 2 cycles between bits -> same result 4'b1011, with no extra latency after the last bit.
- Restart: 2 bits sent, then start with the frame 0,1,1,0 -> frame_restart pulses once, result=4'b0110, and no result from the aborted frame.
- Overrun:
  - Two back-to-back frames, 1011 then 0111, with no ack -> result=4'b0111 and overrun=1, held until reset.
  - Repeat with the ack on the completion cycle of the second frame -> overrun stays 0.
- Async reset mid-frame: reset low after 2 bits -> all outputs go 0 immediately; a later full frame decodes correctly.
- SERIAL_SUM_CHECK_EN:
  - a=3'b101, b=3'b110 with the correct bit_in stream -> sum_err=0.
  - Flip bit 2 of bit_in -> sum_err=1 with result_valid; it clears on ack.
